// File: rtl/booth_multiplier.sv
// ---------------------------------------------------------------------------
// booth_multiplier
//
// Sequential radix-2 Booth multiplier for signed two's-complement operands.
// A start request in IDLE captures the operands. One Booth step is then
// performed per clock for WIDTH clocks, and the signed 2*WIDTH-bit product
// is registered onto out when the last step completes.
//
// Parameters:
//   WIDTH  operand width in bits (>= 2); the product is 2*WIDTH bits
//
// Ports:
//   clk    input   rising-edge clock
//   rst    input   asynchronous active-high reset
//   mc     input   signed multiplicand, sampled only on the start edge
//   mp     input   signed multiplier, sampled only on the start edge
//   start  input   level request, honoured only while idle
//   out    output  registered signed product; holds the last completed result
//   busy   output  high while a multiplication is in progress
//   done   output  one-cycle completion pulse (only with BOOTH_DONE_PULSE_EN)
//
// Optional feature macro: BOOTH_DONE_PULSE_EN adds the registered done port.
// ---------------------------------------------------------------------------
module booth_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   mc,
    input  logic [WIDTH-1:0]   mp,
    input  logic               start,
    output logic [2*WIDTH-1:0] out,
    output logic               busy
`ifdef BOOTH_DONE_PULSE_EN
    ,
    output logic               done
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] out_q, out_d;

    logic [WIDTH:0]     stepSum;
    logic [WIDTH-1:0]   stepA;
    logic [WIDTH-1:0]   stepQ;

`ifdef BOOTH_DONE_PULSE_EN
    logic done_q, done_d;
`endif

    // One Booth step on the current {A,Q,Q_1}.
    // The add/subtract is carried one bit wider than A. A's stored value is
    // still WIDTH-bit modulo, but the extra bit holds the true sign of the
    // sum. That sign is what the arithmetic shift must replicate. With the
    // most negative multiplicand, A-M overflows WIDTH bits, and shifting in
    // the truncated sign would corrupt the product. After the shift, A always
    // fits back into WIDTH bits, so nothing is lost.
    always_comb begin
        case ({q_q[0], q1_q})
            2'b01:   stepSum = {a_q[WIDTH-1], a_q} + {m_q[WIDTH-1], m_q};
            2'b10:   stepSum = {a_q[WIDTH-1], a_q} - {m_q[WIDTH-1], m_q};
            default: stepSum = {a_q[WIDTH-1], a_q};
        endcase
        stepA = stepSum[WIDTH:1];
        stepQ = {stepSum[0], q_q[WIDTH-1:1]};
    end

    // Next-state logic. In IDLE, a start request loads the operands. In RUN,
    // each clock applies one step. The step that brings the count to WIDTH
    // writes the product and returns to IDLE. start is not examined during
    // RUN, so a request while busy is simply ignored.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        q1_d    = q1_q;
        count_d = count_q;
        out_d   = out_q;
`ifdef BOOTH_DONE_PULSE_EN
        done_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = mc;
                    q_d     = mp;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = stepA;
                q_d     = stepQ;
                q1_d    = q_q[0];
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    out_d   = {stepA, stepQ};
                    state_d = IDLE;
`ifdef BOOTH_DONE_PULSE_EN
                    done_d  = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any run immediately and
    // clears the visible result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

`ifdef BOOTH_DONE_PULSE_EN
    // Completion pulse register. It is high only on the cycle after out is
    // written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
`endif

    assign out  = out_q;
    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_booth_multiplier.sv
// ---------------------------------------------------------------------------
// tb_booth_multiplier
//
// Self-checking bench for booth_multiplier (WIDTH = 8).
//
// The driver issues operand pairs and pushes the exact signed product,
// computed with plain integer arithmetic, into a queue. A monitor on the
// falling clock edge pops the queue at each busy falling edge and checks
// the product. It also checks that out never changes outside a completion,
// that busy stays high for exactly WIDTH cycles and, when built with
// BOOTH_DONE_PULSE_EN, that done pulses only at completion.
// ---------------------------------------------------------------------------
module tb_booth_multiplier;

    localparam int WIDTH = 8;
    localparam int PW    = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] mp;
    logic             start;
    logic [PW-1:0]    out;
    logic             busy;
`ifdef BOOTH_DONE_PULSE_EN
    logic             done;
`endif

    int errors = 0;
    int checks = 0;

    logic [PW-1:0] expQ[$];
    logic [PW-1:0] heldOut = '0;
    logic          prevBusy = 1'b0;
    int            busyCycles = 0;

    booth_multiplier #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .mc    (mc),
        .mp    (mp),
        .start (start),
        .out   (out),
        .busy  (busy)
`ifdef BOOTH_DONE_PULSE_EN
        ,
        .done  (done)
`endif
    );

    always #5 clk = ~clk;

    // Exact signed product of two WIDTH-bit operands, truncated to PW bits.
    function automatic logic [PW-1:0] refProduct(input logic signed [WIDTH-1:0] a,
                                                 input logic signed [WIDTH-1:0] b);
        longint pa;
        longint pb;
        longint p;
        pa = longint'(a);
        pb = longint'(b);
        p  = pa * pb;
        return p[PW-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Presents one operand pair with start on the next falling edge, queues
    // the expected product and confirms that busy rises on the load edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input bit keepStart);
        @(negedge clk);
        mc    = a;
        mp    = b;
        start = 1'b1;
        expQ.push_back(refProduct(a, b));
        @(posedge clk);
        #1;
        checkOutput("busy_after_load", 64'(busy), 64'(1));
        if (!keepStart) start = 1'b0;
    endtask

    // Waits, with a cycle budget, for the current run to finish.
    task automatic waitIdle();
        int n = 0;
        while (busy === 1'b1 && n < 4 * WIDTH) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) checkOutput("idle_timeout", 64'(busy), 64'(0));
    endtask

    // Monitor: checks completions against the scoreboard and checks that out
    // holds its value at every other cycle.
    always @(negedge clk) begin
        logic [PW-1:0] expProd;
        if (rst) begin
            prevBusy   = 1'b0;
            busyCycles = 0;
            heldOut    = '0;
            expQ.delete();
        end else begin
`ifdef BOOTH_DONE_PULSE_EN
            checkOutput("done_pulse", 64'(done), 64'(prevBusy && !busy));
`endif
            if (busy) begin
                busyCycles++;
                checkOutput("out_hold", 64'(out), 64'(heldOut));
            end else if (prevBusy) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_completion", 64'(1), 64'(0));
                end else begin
                    expProd = expQ.pop_front();
                    checkOutput("product", 64'(out), 64'(expProd));
                    heldOut = expProd;
                end
                checkOutput("busy_cycles", 64'(busyCycles), 64'(WIDTH));
                busyCycles = 0;
            end else begin
                checkOutput("out_idle_hold", 64'(out), 64'(heldOut));
            end
            prevBusy = busy;
        end
    end

    // Main stimulus sequence.
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mc    = '0;
        mp    = '0;
        #12;
        checkOutput("reset_out", 64'(out), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Basic latency case and directed corner products.
        applyStimulus(WIDTH'(5), WIDTH'(4), 1'b0);
        waitIdle();
        checkOutput("first_product_direct", 64'(out), 64'(16'h0014));
        applyStimulus(WIDTH'(-3), WIDTH'(7), 1'b0);
        waitIdle();
        applyStimulus(WIDTH'(-128), WIDTH'(-128), 1'b0);
        waitIdle();
        checkOutput("min_times_min_direct", 64'(out), 64'(16'h4000));
        applyStimulus(WIDTH'(-128), WIDTH'(127), 1'b0);
        waitIdle();
        applyStimulus(WIDTH'(127), WIDTH'(127), 1'b0);
        waitIdle();
        applyStimulus(WIDTH'(-1), WIDTH'(-1), 1'b0);
        waitIdle();
        applyStimulus(WIDTH'(0), WIDTH'(-128), 1'b0);
        waitIdle();

        // Operand changes and start requests while busy must be ignored.
        applyStimulus(WIDTH'(6), WIDTH'(6), 1'b0);
        repeat (2) @(negedge clk);
        mc    = WIDTH'(9);
        mp    = WIDTH'(9);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        waitIdle();
        checkOutput("ignored_start_product", 64'(out), 64'(16'h0024));
        repeat (3) @(negedge clk);
        checkOutput("no_restart", 64'(busy), 64'(0));

        // Asynchronous reset between the 4th and 5th edges of a run.
        applyStimulus(WIDTH'(7), WIDTH'(9), 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrun_reset_out", 64'(out), 64'(0));
        checkOutput("midrun_reset_busy", 64'(busy), 64'(0));
        #4;
        rst = 1'b0;
        applyStimulus(WIDTH'(2), WIDTH'(3), 1'b0);
        waitIdle();
        checkOutput("after_reset_product", 64'(out), 64'(16'h0006));

        // start held high: the second run loads one idle cycle after the first
        // completes.
        applyStimulus(WIDTH'(1), WIDTH'(-1), 1'b1);
        waitIdle();
        mc = WIDTH'(0);
        mp = WIDTH'(55);
        expQ.push_back(refProduct(WIDTH'(0), WIDTH'(55)));
        @(posedge clk);
        #1;
        checkOutput("back_to_back_reload", 64'(busy), 64'(1));
        start = 1'b0;
        waitIdle();

        // Random operand pairs.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'b0);
            waitIdle();
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
